// File: rtl/ram_port_ctrl_if.sv
// Request, response and RAM-side signals of one ram_port_ctrl port.
// slave: the controller; master: the requester and the RAM together.
interface ram_port_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BYTE_WIDTH = 8
);
    localparam int unsigned BytesPerWord = DATA_WIDTH / BYTE_WIDTH;

    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [BytesPerWord-1:0] req_strobe;
    logic [DATA_WIDTH-1:0]   req_wdata;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_write;

    logic                    ram_en;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [BytesPerWord-1:0] ram_strobe;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    modport slave (
        input  req_valid, req_addr, req_strobe, req_wdata, resp_ready, ram_rdata,
        output req_ready, resp_valid, resp_rdata, resp_write,
        output ram_en, ram_addr, ram_strobe, ram_wdata
    );

    modport master (
        output req_valid, req_addr, req_strobe, req_wdata, resp_ready, ram_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_write,
        input  ram_en, ram_addr, ram_strobe, ram_wdata
    );
endinterface

// File: rtl/ram_port_ctrl.sv
// Valid/ready front end for one block-RAM port: latency tracker plus credit-protected response FIFO.
// Optional RAM_PORT_CTRL_BYPASS_EN: returning data skips an empty FIFO when the consumer is ready.
module ram_port_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 17,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned RESP_DEPTH   = 4
) (
    input logic            clk,
    input logic            resetn,
    ram_port_ctrl_if.slave bus
);
    localparam int unsigned BytesPerWord = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned PtrW         = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CntW         = $clog2(RESP_DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(RESP_DEPTH - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(RESP_DEPTH);

    if (READ_LATENCY == 0) begin : g_check_latency
        $error("ram_port_ctrl: READ_LATENCY must be at least 1");
    end
    if (RESP_DEPTH == 0) begin : g_check_depth
        $error("ram_port_ctrl: RESP_DEPTH must be at least 1");
    end

    logic [ADDR_WIDTH-1:0]   addr;
    logic [BytesPerWord-1:0] strobe;
    logic                    accept;
    logic                    last_valid;
    logic                    last_write;
    logic                    bypass;
    logic                    push;
    logic                    pop;
    logic                    resp_done;
    logic                    fifo_empty;

    logic [READ_LATENCY-1:0] trk_valid_q, trk_valid_d;
    logic [READ_LATENCY-1:0] trk_write_q, trk_write_d;
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [CntW-1:0]         credit_q, credit_d;
    logic [DATA_WIDTH-1:0]   fifo_data_q [RESP_DEPTH];
    logic [RESP_DEPTH-1:0]   fifo_write_q;

    assign addr   = bus.req_addr;
    assign strobe = bus.req_strobe;

    // Credit covers both in-flight RAM reads and queued entries, so the FIFO cannot overflow.
    assign bus.req_ready = resetn && (credit_q < DepthCnt);
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.ram_en     = accept;
    assign bus.ram_addr   = addr;
    assign bus.ram_strobe = strobe;
    assign bus.ram_wdata  = bus.req_wdata;

    assign last_valid = trk_valid_q[READ_LATENCY-1];
    assign last_write = trk_write_q[READ_LATENCY-1];
    assign fifo_empty = (count_q == '0);

`ifdef RAM_PORT_CTRL_BYPASS_EN
    assign bypass = last_valid && fifo_empty && bus.resp_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push      = last_valid && !bypass;
    assign pop       = !fifo_empty && bus.resp_ready;
    assign resp_done = pop || bypass;

    assign bus.resp_valid = resetn && (!fifo_empty || bypass);

    always_comb begin
        bus.resp_rdata = '0;
        bus.resp_write = 1'b0;
        if (resetn) begin
            if (!fifo_empty) begin
                bus.resp_rdata = fifo_data_q[rd_ptr_q];
                bus.resp_write = fifo_write_q[rd_ptr_q];
            end else if (bypass) begin
                bus.resp_rdata = bus.ram_rdata;
                bus.resp_write = last_write;
            end
        end
    end

    always_comb begin
        trk_valid_d    = '0;
        trk_write_d    = '0;
        trk_valid_d[0] = accept;
        trk_write_d[0] = accept && (|strobe);
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            trk_valid_d[i] = trk_valid_q[i-1];
            trk_write_d[i] = trk_write_q[i-1];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        // A response delivered this cycle returns its credit at the next edge only.
        credit_d = credit_q;
        if (accept && !resp_done) begin
            credit_d = credit_q + 1'b1;
        end else if (!accept && resp_done) begin
            credit_d = credit_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            trk_valid_q <= '0;
            trk_write_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            credit_q    <= '0;
        end else begin
            trk_valid_q <= trk_valid_d;
            trk_write_q <= trk_write_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            credit_q    <= credit_d;
        end
    end

    // Storage needs no reset: entries are only read while the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q]  <= bus.ram_rdata;
            fifo_write_q[wr_ptr_q] <= last_write;
        end
    end
endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl: depth-4 and depth-3 instances, each with a read-first RAM model.
module tb_ram_port_ctrl;
    localparam int unsigned AW = 17;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = 8;
`ifdef RAM_PORT_CTRL_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic ram_clear = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus4 ();
    ram_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus3 ();

    ram_port_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .READ_LATENCY(2), .RESP_DEPTH(4)
    ) dut4 (
        .clk(clk), .resetn(resetn), .bus(bus4)
    );

    ram_port_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .READ_LATENCY(2), .RESP_DEPTH(3)
    ) dut3 (
        .clk(clk), .resetn(resetn), .bus(bus3)
    );

    function automatic logic [63:0] init_word(input logic [31:0] tag, input int a);
        logic [7:0] lo;
        lo = a[7:0];
        return (a >= 'h40) ? {tag, 24'h0, lo} : 64'h0;
    endfunction

    // Read-first RAM models, latency 2, independent of the controller reset.
    logic [63:0] mem4 [256];
    logic [63:0] pipe4 [2];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) mem4[i] <= init_word(32'hC0DE_0000, i);
        end else if (bus4.ram_en) begin
            pipe4[0] <= mem4[bus4.ram_addr[7:0]];
            for (int b = 0; b < 8; b++)
                if (bus4.ram_strobe[b]) mem4[bus4.ram_addr[7:0]][8*b +: 8] <= bus4.ram_wdata[8*b +: 8];
        end
        pipe4[1] <= pipe4[0];
    end
    assign bus4.ram_rdata = pipe4[1];

    logic [63:0] mem3 [256];
    logic [63:0] pipe3 [2];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int j = 0; j < 256; j++) mem3[j] <= init_word(32'hBEEF_0000, j);
        end else if (bus3.ram_en) begin
            pipe3[0] <= mem3[bus3.ram_addr[7:0]];
            for (int b = 0; b < 8; b++)
                if (bus3.ram_strobe[b]) mem3[bus3.ram_addr[7:0]][8*b +: 8] <= bus3.ram_wdata[8*b +: 8];
        end
        pipe3[1] <= pipe3[0];
    end
    assign bus3.ram_rdata = pipe3[1];

    // Response monitors: record handshakes, check credit limit and response stability.
    logic [63:0] r4_data [$];
    logic        r4_write [$];
    int          r4_cyc [$];
    int          acc4 = 0, rsp4 = 0;
    logic        hold4 = 1'b0;
    logic [63:0] hold4_data;
    logic        hold4_write;

    always @(negedge clk) begin
        #2;
        if (!resetn) begin
            acc4 = 0; rsp4 = 0; hold4 = 1'b0;
        end else begin
            if (hold4) begin
                vectors++;
                if (bus4.resp_valid !== 1'b1 || bus4.resp_rdata !== hold4_data ||
                    bus4.resp_write !== hold4_write) begin
                    miscompares++;
                    $display("FAIL resp_hold4: valid=%b rdata=%h write=%b, required 1 %h %b",
                             bus4.resp_valid, bus4.resp_rdata, bus4.resp_write,
                             hold4_data, hold4_write);
                end
            end
            if (bus4.req_valid && bus4.req_ready) begin
                vectors++;
                if (acc4 - rsp4 >= 4) begin
                    miscompares++;
                    $display("FAIL credit4: accepted with %0d outstanding, required < 4",
                             acc4 - rsp4);
                end
                acc4++;
            end
            if (bus4.resp_valid && bus4.resp_ready) begin
                r4_data.push_back(bus4.resp_rdata);
                r4_write.push_back(bus4.resp_write);
                r4_cyc.push_back(cyc);
                rsp4++;
            end
            hold4       = bus4.resp_valid && !bus4.resp_ready;
            hold4_data  = bus4.resp_rdata;
            hold4_write = bus4.resp_write;
        end
    end

    logic [63:0] r3_data [$];
    logic        r3_write [$];
    int          acc3 = 0, rsp3 = 0;

    always @(negedge clk) begin
        #2;
        if (!resetn) begin
            acc3 = 0; rsp3 = 0;
        end else begin
            if (bus3.req_valid && bus3.req_ready) begin
                vectors++;
                if (acc3 - rsp3 >= 3) begin
                    miscompares++;
                    $display("FAIL credit3: accepted with %0d outstanding, required < 3",
                             acc3 - rsp3);
                end
                acc3++;
            end
            if (bus3.resp_valid && bus3.resp_ready) begin
                r3_data.push_back(bus3.resp_rdata);
                r3_write.push_back(bus3.resp_write);
                rsp3++;
            end
        end
    end

    task automatic drive4(input logic v, input logic [16:0] a, input logic [7:0] s,
                          input logic [63:0] d);
        bus4.req_valid = v; bus4.req_addr = a; bus4.req_strobe = s; bus4.req_wdata = d;
    endtask

    task automatic clear4();
        r4_data.delete(); r4_write.delete(); r4_cyc.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        drive4(1'b1, 17'h5, 8'h00, 64'h0);
        #1;
        vectors++;
        if (bus4.req_ready !== 1'b0) begin
            miscompares++; $display("FAIL rst_req_ready: got %b, required 0", bus4.req_ready);
        end
        vectors++;
        if (bus4.resp_valid !== 1'b0 || bus4.resp_write !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_resp: valid=%b write=%b, required 0 0",
                     bus4.resp_valid, bus4.resp_write);
        end
        vectors++;
        if (bus4.resp_rdata !== 64'h0) begin
            miscompares++; $display("FAIL rst_rdata: got %h, required 0", bus4.resp_rdata);
        end
        vectors++;
        if (bus4.ram_en !== 1'b0) begin
            miscompares++; $display("FAIL rst_ram_en: got %b, required 0", bus4.ram_en);
        end
        @(negedge clk);
        ram_clear = 1'b0;
        drive4(1'b0, 17'h0, 8'h00, 64'h0);
        resetn = 1'b1;
        #1;
        vectors++;
        if (bus4.req_ready !== 1'b1 || bus4.resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_release: ready=%b valid=%b, required 1 0",
                     bus4.req_ready, bus4.resp_valid);
        end
    endtask

    task automatic test_write_read();
        int c;
        clear4();
        bus4.resp_ready = 1'b1;
        @(negedge clk);
        drive4(1'b1, 17'h10, 8'hFF, 64'h1122_3344_5566_7788);
        #1;
        c = cyc;
        vectors++;
        if (bus4.req_ready !== 1'b1 || bus4.ram_en !== 1'b1 || bus4.ram_strobe !== 8'hFF ||
            bus4.ram_addr !== 17'h10) begin
            miscompares++;
            $display("FAIL wr_issue: ready=%b en=%b strobe=%h addr=%h, required 1 1 ff 10",
                     bus4.req_ready, bus4.ram_en, bus4.ram_strobe, bus4.ram_addr);
        end
        @(negedge clk);
        drive4(1'b1, 17'h10, 8'h00, 64'h0);
        #1;
        vectors++;
        if (bus4.ram_en !== 1'b1 || bus4.ram_strobe !== 8'h00) begin
            miscompares++;
            $display("FAIL rd_issue: en=%b strobe=%h, required 1 00", bus4.ram_en, bus4.ram_strobe);
        end
        @(negedge clk);
        drive4(1'b0, 17'h0, 8'h00, 64'h0);
        for (int i = 0; i < 20 && r4_data.size() < 2; i++) @(negedge clk);
        vectors++;
        if (r4_data.size() != 2) begin
            miscompares++;
            $display("FAIL wr_rd_count: got %0d responses, required 2", r4_data.size());
        end else begin
            vectors++;
            if (r4_write[0] !== 1'b1 || r4_data[0] !== 64'h0 || r4_cyc[0] !== c + LAT) begin
                miscompares++;
                $display("FAIL wr_resp: write=%b rdata=%h cycle=%0d, required 1 0 %0d",
                         r4_write[0], r4_data[0], r4_cyc[0], c + LAT);
            end
            vectors++;
            if (r4_write[1] !== 1'b0 || r4_data[1] !== 64'h1122_3344_5566_7788 ||
                r4_cyc[1] !== c + 1 + LAT) begin
                miscompares++;
                $display("FAIL rd_resp: write=%b rdata=%h cycle=%0d, required 0 %h %0d",
                         r4_write[1], r4_data[1], r4_cyc[1], 64'h1122_3344_5566_7788,
                         c + 1 + LAT);
            end
        end
    endtask

    task automatic test_partial_write();
        clear4();
        @(negedge clk);
        drive4(1'b1, 17'h20, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        drive4(1'b1, 17'h20, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB);
        @(negedge clk);
        drive4(1'b1, 17'h20, 8'h00, 64'h0);
        @(negedge clk);
        drive4(1'b0, 17'h0, 8'h00, 64'h0);
        for (int i = 0; i < 20 && r4_data.size() < 3; i++) @(negedge clk);
        vectors++;
        if (r4_data.size() != 3) begin
            miscompares++;
            $display("FAIL partial_count: got %0d responses, required 3", r4_data.size());
        end else begin
            vectors++;
            if (r4_write[1] !== 1'b1 || r4_data[1] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
                miscompares++;
                $display("FAIL partial_old: write=%b rdata=%h, required 1 ffffffffffffffff",
                         r4_write[1], r4_data[1]);
            end
            vectors++;
            if (r4_write[2] !== 1'b0 || r4_data[2] !== 64'hFFFF_FFFF_BBBB_BBBB) begin
                miscompares++;
                $display("FAIL partial_merge: write=%b rdata=%h, required 0 ffffffffbbbbbbbb",
                         r4_write[2], r4_data[2]);
            end
        end
    endtask

    task automatic test_throughput();
        int c0;
        clear4();
        bus4.resp_ready = 1'b1;
        c0 = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            drive4(1'b1, 17'(32'h40 + k), 8'h00, 64'h0);
            #1;
            if (k == 0) c0 = cyc;
            vectors++;
            if (bus4.req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL tput_ready: read %0d ready=%b, required 1", k, bus4.req_ready);
            end
        end
        @(negedge clk);
        drive4(1'b0, 17'h0, 8'h00, 64'h0);
        for (int i = 0; i < 40 && r4_data.size() < 16; i++) @(negedge clk);
        vectors++;
        if (r4_data.size() != 16) begin
            miscompares++;
            $display("FAIL tput_count: got %0d responses, required 16", r4_data.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                vectors++;
                if (r4_data[k] !== init_word(32'hC0DE_0000, 'h40 + k) || r4_cyc[k] !== c0 + k + LAT)
                begin
                    miscompares++;
                    $display("FAIL tput_resp%0d: rdata=%h cycle=%0d, required %h %0d", k,
                             r4_data[k], r4_cyc[k], init_word(32'hC0DE_0000, 'h40 + k),
                             c0 + k + LAT);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        clear4();
        bus4.resp_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive4(1'b1, 17'(32'h50 + acc), 8'h00, 64'h0);
            #1;
            if (bus4.req_ready) acc++;
        end
        @(negedge clk);
        drive4(1'b0, 17'h0, 8'h00, 64'h0);
        #1;
        vectors++;
        if (acc != 4) begin
            miscompares++; $display("FAIL bp_accepted: got %0d, required 4", acc);
        end
        vectors++;
        if (bus4.req_ready !== 1'b0) begin
            miscompares++; $display("FAIL bp_ready_low: got %b, required 0", bus4.req_ready);
        end
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (bus4.resp_valid !== 1'b1 || bus4.resp_rdata !== init_word(32'hC0DE_0000, 'h50)) begin
            miscompares++;
            $display("FAIL bp_head: valid=%b rdata=%h, required 1 %h", bus4.resp_valid,
                     bus4.resp_rdata, init_word(32'hC0DE_0000, 'h50));
        end
        @(negedge clk);
        bus4.resp_ready = 1'b1;
        #1;
        vectors++;
        if (bus4.req_ready !== 1'b0) begin
            miscompares++; $display("FAIL bp_pop_cycle: ready=%b, required 0", bus4.req_ready);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus4.req_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_reassert: ready=%b, required 1", bus4.req_ready);
        end
        for (int i = 0; i < 20 && r4_data.size() < 4; i++) @(negedge clk);
        vectors++;
        if (r4_data.size() != 4) begin
            miscompares++;
            $display("FAIL bp_count: got %0d responses, required 4", r4_data.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (r4_data[k] !== init_word(32'hC0DE_0000, 'h50 + k)) begin
                    miscompares++;
                    $display("FAIL bp_resp%0d: rdata=%h, required %h", k, r4_data[k],
                             init_word(32'hC0DE_0000, 'h50 + k));
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        clear4();
        bus4.resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive4(1'b1, 17'(32'h60 + k), 8'h00, 64'h0);
            #1;
            vectors++;
            if (bus4.req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL mid_issue%0d: ready=%b, required 1", k, bus4.req_ready);
            end
        end
        @(negedge clk);
        drive4(1'b0, 17'h0, 8'h00, 64'h0);
        @(negedge clk);
        #1;
        vectors++;
        if (bus4.resp_valid !== 1'b1) begin
            miscompares++; $display("FAIL mid_queued: valid=%b, required 1", bus4.resp_valid);
        end
        drive4(1'b1, 17'h70, 8'h00, 64'h0);
        resetn = 1'b0;
        #1;
        vectors++;
        if (bus4.resp_valid !== 1'b0 || bus4.resp_rdata !== 64'h0 || bus4.resp_write !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_resp: valid=%b rdata=%h write=%b, required 0 0 0",
                     bus4.resp_valid, bus4.resp_rdata, bus4.resp_write);
        end
        vectors++;
        if (bus4.req_ready !== 1'b0 || bus4.ram_en !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_req: ready=%b en=%b, required 0 0",
                     bus4.req_ready, bus4.ram_en);
        end
        @(negedge clk);
        drive4(1'b0, 17'h0, 8'h00, 64'h0);
        @(negedge clk);
        resetn = 1'b1;
        bus4.resp_ready = 1'b1;
        clear4();
        @(negedge clk);
        #1;
        vectors++;
        if (bus4.req_ready !== 1'b1) begin
            miscompares++; $display("FAIL mid_ready_after: ready=%b, required 1", bus4.req_ready);
        end
        repeat (8) @(negedge clk);
        vectors++;
        if (r4_data.size() != 0) begin
            miscompares++;
            $display("FAIL mid_stale: got %0d responses, required 0", r4_data.size());
        end
    endtask

    task automatic test_depth3_wrap();
        int total;
        int issued;
        int k;
        total = 0;
        r3_data.delete(); r3_write.delete();
        for (int b = 0; b < 10; b++) begin
            issued = 0;
            k = 0;
            while (issued < 1 + (b % 4) && k < 60) begin
                @(negedge clk);
                bus3.resp_ready = (b % 2 == 1) || (k % 3 == 2);
                bus3.req_valid  = 1'b1;
                bus3.req_addr   = 17'(32'h80 + total);
                bus3.req_strobe = 8'h00;
                bus3.req_wdata  = 64'h0;
                #1;
                if (bus3.req_ready) begin
                    issued++;
                    total++;
                end
                k++;
            end
            @(negedge clk);
            bus3.req_valid  = 1'b0;
            bus3.resp_ready = 1'b0;
        end
        vectors++;
        if (total != 23) begin
            miscompares++; $display("FAIL d3_issued: got %0d, required 23", total);
        end
        bus3.resp_ready = 1'b1;
        for (int i = 0; i < 100 && r3_data.size() < total; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        vectors++;
        if (r3_data.size() != 23) begin
            miscompares++;
            $display("FAIL d3_count: got %0d responses, required 23", r3_data.size());
        end else begin
            for (int n = 0; n < 23; n++) begin
                vectors++;
                if (r3_data[n] !== init_word(32'hBEEF_0000, 'h80 + n) || r3_write[n] !== 1'b0)
                begin
                    miscompares++;
                    $display("FAIL d3_resp%0d: rdata=%h write=%b, required %h 0", n, r3_data[n],
                             r3_write[n], init_word(32'hBEEF_0000, 'h80 + n));
                end
            end
        end
    endtask

    initial begin
        drive4(1'b0, 17'h0, 8'h00, 64'h0);
        bus4.resp_ready = 1'b0;
        bus3.req_valid  = 1'b0;
        bus3.req_addr   = 17'h0;
        bus3.req_strobe = 8'h00;
        bus3.req_wdata  = 64'h0;
        bus3.resp_ready = 1'b0;
        #1 resetn = 1'b0;
        test_reset();
        test_write_read();
        test_partial_write();
        test_throughput();
        test_backpressure();
        test_reset_midflight();
        test_depth3_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
